alu_pipe_seq: RTL and testbench



---
 rtl/alu_pipe_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_pipe_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_seq.sv
// alu_pipe_seq: registered, handshaked ALU with WIDTH-bit operands.
// Base ops (ADD..OR) complete in one cycle through the output register.
// Optional macro ALU_SHIFT_EN builds an iterative 1-bit/cycle shifter
// (SLL/SRL/SRA); without it, commands 8..10 report illegal.
module alu_pipe_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [3:0]       command,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   localparam logic [3:0] CmdAdd  = 4'd0;
   localparam logic [3:0] CmdSub  = 4'd1;
   localparam logic [3:0] CmdXor  = 4'd2;
   localparam logic [3:0] CmdSlt  = 4'd3;
   localparam logic [3:0] CmdAnd  = 4'd4;
   localparam logic [3:0] CmdNand = 4'd5;
   localparam logic [3:0] CmdNor  = 4'd6;
   localparam logic [3:0] CmdOr   = 4'd7;

`ifdef ALU_SHIFT_EN
   localparam int SHW = $clog2(WIDTH);
   localparam logic [3:0] CmdSll = 4'd8;
   localparam logic [3:0] CmdSrl = 4'd9;
   localparam logic [3:0] CmdSra = 4'd10;

   typedef enum logic {IDLE, SHIFT} state_t;
`else
   typedef enum logic {IDLE} state_t;
`endif

   state_t           state;
   logic             accept;
   logic [WIDTH-1:0] bOp;
   logic             subMode;
   logic [WIDTH-1:0] sum;
   logic             sumCarry;
   logic             sumOvf;
   logic [WIDTH-1:0] baseRes;
   logic             baseCarry;
   logic             baseOvf;
   logic             baseIllegal;

`ifdef ALU_SHIFT_EN
   logic [WIDTH-1:0] shReg;
   logic [WIDTH-1:0] shNext;
   logic [SHW-1:0]   shCnt;
   logic [3:0]       shCmd;
   logic [SHW-1:0]   shiftAmt;
   logic             startShift;
`endif

   assign in_ready = (state == IDLE) & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   // Adder/subtractor shared by ADD, SUB and SLT, plus the one-cycle result mux
   always_comb begin
      subMode = (command == CmdSub) || (command == CmdSlt);
      bOp     = subMode ? ~operand_b : operand_b;
      {sumCarry, sum} = {1'b0, operand_a} + {1'b0, bOp} + (WIDTH + 1)'(subMode);
      sumOvf  = (operand_a[WIDTH-1] == bOp[WIDTH-1]) & (sum[WIDTH-1] != operand_a[WIDTH-1]);
      baseRes     = '0;
      baseCarry   = 1'b0;
      baseOvf     = 1'b0;
      baseIllegal = 1'b0;
      case (command)
         CmdAdd, CmdSub: begin
            baseRes   = sum;
            baseCarry = sumCarry;
            baseOvf   = sumOvf;
         end
         CmdSlt: begin
            baseRes[0] = sum[WIDTH-1] ^ sumOvf;
            baseCarry  = sumCarry;
            baseOvf    = sumOvf;
         end
         CmdXor:  baseRes = operand_a ^ operand_b;
         CmdAnd:  baseRes = operand_a & operand_b;
         CmdNand: baseRes = ~(operand_a & operand_b);
         CmdNor:  baseRes = ~(operand_a | operand_b);
         CmdOr:   baseRes = operand_a | operand_b;
`ifdef ALU_SHIFT_EN
         // Zero-amount shifts complete here as a pass-through of operand_a
         CmdSll, CmdSrl, CmdSra: baseRes = operand_a;
`endif
         default: baseIllegal = 1'b1;
      endcase
   end

`ifdef ALU_SHIFT_EN
   // Single-bit step of the iterative shifter and the shift-start decision
   always_comb begin
      shiftAmt   = operand_b[SHW-1:0];
      startShift = ((command == CmdSll) || (command == CmdSrl) || (command == CmdSra))
                   && (shiftAmt != '0);
      case (shCmd)
         CmdSll:  shNext = {shReg[WIDTH-2:0], 1'b0};
         CmdSra:  shNext = {shReg[WIDTH-1], shReg[WIDTH-1:1]};
         default: shNext = {1'b0, shReg[WIDTH-1:1]};
      endcase
   end
`endif

   // FSM, shifter state and output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         carryout  <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
`ifdef ALU_SHIFT_EN
         shReg     <= '0;
         shCnt     <= '0;
         shCmd     <= '0;
`endif
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
`ifdef ALU_SHIFT_EN
                  if (startShift) begin
                     state <= SHIFT;
                     shReg <= operand_a;
                     shCnt <= shiftAmt;
                     shCmd <= command;
                  end else
`endif
                  begin
                     out_valid <= 1'b1;
                     result    <= baseRes;
                     carryout  <= baseCarry;
                     overflow  <= baseOvf;
                     illegal   <= baseIllegal;
                     zero      <= (baseRes == '0);
                  end
               end
            end
`ifdef ALU_SHIFT_EN
            SHIFT: begin
               // Final step loads the shifted value directly, so the
               // output appears amt cycles after the shifter is loaded.
               shReg <= shNext;
               shCnt <= shCnt - SHW'(1);
               if (shCnt == SHW'(1)) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  result    <= shNext;
                  carryout  <= 1'b0;
                  overflow  <= 1'b0;
                  illegal   <= 1'b0;
                  zero      <= (shNext == '0);
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Scoreboard bench for alu_pipe_seq (WIDTH=32); honours ALU_SHIFT_EN.
module tb_alu_pipe_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic [3:0]   command;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carryout;
   logic         zero;
   logic         overflow;
   logic         illegal;

   alu_pipe_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .command(command),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carryout(carryout), .zero(zero), .overflow(overflow), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         c, z, o, ill;
      int unsigned  rdy;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          errors = 0;
   int unsigned busyEnd = 0;
   bit          holding = 0;
   int unsigned firstSeen = 0;

   // Reference ALU using plain integer arithmetic
   function automatic void model(input logic [3:0] cmd, input logic [W-1:0] x,
                                 input logic [W-1:0] y, output exp_t e,
                                 output int unsigned lat);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint lo = -(longint'(1) << (W - 1));
      longint hi = (longint'(1) << (W - 1)) - 1;
      longint d;
      logic [W:0] wide;
      int unsigned amt = int'(y[4:0]);
      e.res = '0; e.c = 1'b0; e.o = 1'b0; e.ill = 1'b0; e.rdy = 0;
      lat = 1;
      case (cmd)
         4'd0: begin
            wide = {1'b0, x} + {1'b0, y};
            d = sx + sy;
            e.res = x + y; e.c = wide[W]; e.o = (d > hi) || (d < lo);
         end
         4'd1: begin
            d = sx - sy;
            e.res = x - y; e.c = (x >= y); e.o = (d > hi) || (d < lo);
         end
         4'd2: e.res = x ^ y;
         4'd3: begin
            d = sx - sy;
            e.res = (sx < sy) ? 1 : 0; e.c = (x >= y); e.o = (d > hi) || (d < lo);
         end
         4'd4: e.res = x & y;
         4'd5: e.res = ~(x & y);
         4'd6: e.res = ~(x | y);
         4'd7: e.res = x | y;
`ifdef ALU_SHIFT_EN
         4'd8:  begin e.res = x << amt; lat = 1 + amt; end
         4'd9:  begin e.res = x >> amt; lat = 1 + amt; end
         4'd10: begin e.res = W'($signed(x) >>> amt); lat = 1 + amt; end
`endif
         default: e.ill = 1'b1;
      endcase
      e.z = (e.res == '0);
   endfunction

   // One cycle of stimulus; checks in_ready against the model and scoreboards accepts
   task automatic step(input bit v, input logic [3:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit ordy, output bit acc);
      exp_t e;
      int unsigned lat;
      bit expRdy;
      @(posedge clk);
      #1;
      in_valid = v; command = c; operand_a = x; operand_b = y; out_ready = ordy;
      #1;
      expRdy = (cyc >= busyEnd) && !(q.size() > 0 && q[0].rdy <= cyc && !ordy);
      vectors++;
      if (in_ready !== expRdy) begin
         errors++;
         $display("FAIL in_ready cyc=%0d got %b expected %b", cyc, in_ready, expRdy);
      end
      acc = v && in_ready;
      if (acc) begin
         model(c, x, y, e, lat);
         e.rdy = cyc + lat;
         q.push_back(e);
         if (lat > 1) busyEnd = cyc + lat;
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
      bit acc = 0;
      for (int i = 0; i < 60 && !acc; i++) step(1'b1, c, x, y, 1'b1, acc);
      if (!acc) begin
         vectors++; errors++;
         $display("FAIL accept_timeout cmd=%0d got no accept expected accept", c);
      end
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 100 && q.size() > 0; i++) step(1'b0, 4'd0, '0, '0, 1'b1, acc);
      if (q.size() > 0) begin
         vectors++; errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", q.size());
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || carryout !== 1'b0 ||
          zero !== 1'b0 || overflow !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL %s got v=%b rdy=%b res=%h c=%b z=%b o=%b ill=%b expected v=0 rdy=1 all 0",
                  tag, out_valid, in_ready, result, carryout, zero, overflow, illegal);
      end
   endtask

   // Monitor: compares every presented output against the scoreboard head
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (!holding) begin
            holding = 1;
            firstSeen = cyc;
         end
         vectors++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got res=%h expected no output", result);
         end else begin
            if (result !== q[0].res || carryout !== q[0].c || zero !== q[0].z ||
                overflow !== q[0].o || illegal !== q[0].ill) begin
               errors++;
               $display("FAIL result got res=%h c=%b z=%b o=%b ill=%b expected res=%h c=%b z=%b o=%b ill=%b",
                        result, carryout, zero, overflow, illegal,
                        q[0].res, q[0].c, q[0].z, q[0].o, q[0].ill);
            end
            if (out_ready === 1'b1) begin
               vectors++;
               if (firstSeen != q[0].rdy) begin
                  errors++;
                  $display("FAIL latency got cycle %0d expected cycle %0d", firstSeen, q[0].rdy);
               end
               void'(q.pop_front());
               holding = 0;
            end
         end
      end
   end

   initial begin
      bit acc;
      rst_n = 1'b0; in_valid = 1'b0; operand_a = '0; operand_b = '0;
      command = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkIdleOutputs("reset_state");

      // Directed corner cases
      issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
      issue(4'd1, 32'd5, 32'd5);
      issue(4'd3, 32'h8000_0000, 32'h0000_0001);
      issue(4'd3, 32'h0000_0001, 32'h8000_0000);
      issue(4'd10, 32'h8000_0000, 32'd4);
      issue(4'd8, 32'h1234_5678, 32'd0);
      issue(4'd9, 32'hF000_000F, 32'd1);
      issue(4'd9, 32'hDEAD_BEEF, 32'd0);
      issue(4'd12, 32'hFFFF_FFFF, 32'h1);
      issue(4'd15, 32'h1, 32'h1);
      drain();

      // Backpressure: held output, then release with a same-cycle accept
      issue(4'd0, 32'h0000_00F0, 32'h0000_000F);
      for (int i = 0; i < 3; i++) step(1'b1, 4'd7, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, acc);
      step(1'b1, 4'd2, 32'hFFFF_0000, 32'h00FF_FF00, 1'b1, acc);
      vectors++;
      if (!acc) begin
         errors++;
         $display("FAIL release_accept got %b expected 1", acc);
      end
      drain();

      // Reset during a long shift aborts it
      issue(4'd8, 32'h0000_0001, 32'd10);
      step(1'b0, 4'd0, '0, '0, 1'b1, acc);
      @(posedge clk);
      #1 rst_n = 1'b0; in_valid = 1'b0;
      q.delete(); busyEnd = 0; holding = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkIdleOutputs("reset_mid_shift");
      for (int i = 0; i < 12; i++) step(1'b0, 4'd0, '0, '0, 1'b1, acc);

      // Randomised traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         logic [W-1:0] y;
         y = $urandom;
         if ($urandom_range(0, 1) == 0) y[4:0] = 5'($urandom_range(0, 5));
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, y,
              $urandom_range(0, 3) != 0, acc);
      end
      drain();
      step(1'b0, 4'd0, '0, '0, 1'b1, acc);
      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty got %0d expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
